// File: rtl/conv_result_streamer.sv
// Streams MEM_Z words 0..size-1 on valid/ready after done_i; first valid two edges after done_i, 1 word/cycle.
// Backpressure: a 2-entry FWFT FIFO holds data stable while stalled; RAM reads are only issued when a slot is guaranteed.
module conv_result_streamer #(
    parameter int DATA_WIDTH_OUT    = 16,
    parameter int ADDRESS_WIDTH_OUT = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_i,
    input  logic [ADDRESS_WIDTH_OUT:0]   size_z_i,
    output logic [ADDRESS_WIDTH_OUT-1:0] mem_z_addr_o,
    input  logic [DATA_WIDTH_OUT-1:0]    mem_z_data_i,
    output logic [DATA_WIDTH_OUT-1:0]    m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CW = ADDRESS_WIDTH_OUT + 1;
    localparam logic [CW-1:0] MAX_SIZE = {1'b1, {ADDRESS_WIDTH_OUT{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       size_q, size_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                inflight_q, inflight_d;

    logic [DATA_WIDTH_OUT-1:0] fifo_mem_q [2];
    logic                wr_idx_q, wr_idx_d;
    logic                rd_idx_q, rd_idx_d;
    logic [1:0]          occ_q, occ_d;

    logic [CW-1:0]       size_clamped;
    logic                fifo_vld;
    logic                beat;
    logic                last_word;
    logic                issue;
    logic                push;
    logic                pop;
    logic [2:0]          pending;

    assign size_clamped = (size_z_i > MAX_SIZE) ? MAX_SIZE : size_z_i;
    assign fifo_vld     = (occ_q != 2'd0);
    assign beat         = fifo_vld & m_ready_i;
    assign last_word    = (beat_cnt_q == (size_q - CW'(1)));
    assign pending      = {1'b0, occ_q} + {2'b00, inflight_q};
    // A beat frees a slot this edge, so a read may be issued even when both slots are spoken for.
    assign issue        = (state_q == S_STREAM) && (rd_ptr_q < size_q)
                          && ((pending < 3'd2) || beat);
    assign push         = inflight_q;
    assign pop          = beat;

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = issue;
        case (state_q)
            S_IDLE: begin
                if (done_i) begin
                    size_d     = size_clamped;
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (size_clamped == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_word) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_idx_d = push ? ~wr_idx_q : wr_idx_q;
        rd_idx_d = pop ? ~rd_idx_q : rd_idx_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            occ_q      <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
        end else if (push) begin
            fifo_mem_q[wr_idx_q] <= mem_z_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && (occ_q == 2'd2)));
        end
    end

    assign mem_z_addr_o = rd_ptr_q[ADDRESS_WIDTH_OUT-1:0];
    assign m_valid_o    = fifo_vld;
    assign m_data_o     = fifo_vld ? fifo_mem_q[rd_idx_q] : '0;
    assign m_last_o     = fifo_vld && (state_q == S_STREAM) && last_word;
    assign busy_o       = (state_q == S_STREAM);
    assign done_o       = (state_q == S_FINISH);

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: stimulus pushes expected words into a scoreboard, a negedge monitor pops and compares.
module tb_conv_result_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done_i = 1'b0;
    logic [6:0]  size_z_i = '0;
    logic [5:0]  mem_z_addr_o;
    logic [15:0] mem_z_data_i = '0;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        m_last_o;
    logic        busy_o;
    logic        done_o;

    conv_result_streamer #(.DATA_WIDTH_OUT(16), .ADDRESS_WIDTH_OUT(6)) dut (
        .clk(clk), .rst(rst), .done_i(done_i), .size_z_i(size_z_i),
        .mem_z_addr_o(mem_z_addr_o), .mem_z_data_i(mem_z_data_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [64];
    always @(posedge clk) mem_z_data_i <= mem[mem_z_addr_o];

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int beats = 0;
    int first_vld_cyc = -1;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    int start_cyc = 0;
    bit busy_seen = 1'b0;
    int ready_mode = 0;
    int rdy_idx = 0;
    logic [3:0] rdy_pat = 4'b1001;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Ready generator: held high, or the 1,0,0,1 pattern
    always @(posedge clk) begin
        #1;
        rdy_idx++;
        if (ready_mode == 0) m_ready_i = 1'b1;
        else m_ready_i = rdy_pat[3 - (rdy_idx % 4)];
    end

    bit          stall_q = 1'b0;
    logic [15:0] held_data;
    logic        held_last;

    always @(negedge clk) begin
        if (rst) begin
            if (stall_q) begin
                check("stall_valid", {31'b0, m_valid_o}, 32'd1);
                check("stall_data", {16'b0, m_data_o}, {16'b0, held_data});
                check("stall_last", {31'b0, m_last_o}, {31'b0, held_last});
            end
            stall_q = 1'b0;
            if (m_valid_o) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (m_ready_i) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_beat: got data %0h with no expected word", m_data_o);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("beat_data", {16'b0, m_data_o}, {16'b0, e.data});
                        check("beat_last", {31'b0, m_last_o}, {31'b0, e.last});
                    end
                    beats++;
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                end else begin
                    stall_q   = 1'b1;
                    held_data = m_data_o;
                    held_last = m_last_o;
                end
            end
            if (done_o) done_cnt++;
            if (busy_o) busy_seen = 1'b1;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic start(input int size);
        int   n;
        exp_t e;
        n = (size > 64) ? 64 : size;
        for (int i = 0; i < n; i++) begin
            e.data = 16'h1000 + 16'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
        exp_done++;
        start_cyc = cyc + 1;
        done_i   = 1'b1;
        size_z_i = 7'(size);
        step;
        done_i   = 1'b0;
    endtask

    task automatic clear_stats;
        beats = 0;
        first_vld_cyc = -1;
        first_beat_cyc = -1;
        last_beat_cyc = -1;
        busy_seen = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget && done_cnt != exp_done; k++) step;
        check({name, "_done_count"}, done_cnt, exp_done);
        check({name, "_sb_empty"}, sb.size(), 0);
        step;
        check({name, "_idle_busy"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        rst = 1'b0;
        repeat (3) step;
        check("rst_valid", {31'b0, m_valid_o}, 32'd0);
        check("rst_last", {31'b0, m_last_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_data", {16'b0, m_data_o}, 32'd0);
        check("rst_addr", {26'b0, mem_z_addr_o}, 32'd0);
        rst = 1'b1;
        step;

        // 1: 14 words, ready held high
        clear_stats;
        start(14);
        wait_done("t1", 100);
        check("t1_latency", first_vld_cyc - start_cyc, 2);
        check("t1_beats", beats, 14);
        check("t1_back_to_back", last_beat_cyc - first_beat_cyc, 13);

        // 2: ready pattern 1,0,0,1
        clear_stats;
        ready_mode = 1;
        start(14);
        wait_done("t2", 200);
        check("t2_beats", beats, 14);
        ready_mode = 0;
        repeat (2) step;

        // 3: size zero
        clear_stats;
        start(0);
        wait_done("t3", 4);
        check("t3_beats", beats, 0);
        check("t3_busy_seen", {31'b0, busy_seen}, 32'd0);

        // 4: full memory
        clear_stats;
        start(64);
        wait_done("t4", 200);
        check("t4_beats", beats, 64);
        check("t4_back_to_back", last_beat_cyc - first_beat_cyc, 63);

        // 5: reset after the fifth beat, then restart
        clear_stats;
        start(14);
        for (int k = 0; k < 100 && beats < 5; k++) step;
        check("t5_beats_before_rst", beats, 5);
        rst = 1'b0;
        step;
        sb.delete();
        exp_done--;
        check("t5_rst_valid", {31'b0, m_valid_o}, 32'd0);
        check("t5_rst_last", {31'b0, m_last_o}, 32'd0);
        check("t5_rst_busy", {31'b0, busy_o}, 32'd0);
        check("t5_rst_done", {31'b0, done_o}, 32'd0);
        check("t5_rst_data", {16'b0, m_data_o}, 32'd0);
        check("t5_rst_addr", {26'b0, mem_z_addr_o}, 32'd0);
        step;
        rst = 1'b1;
        repeat (3) step;
        check("t5_no_done", done_cnt, exp_done);
        clear_stats;
        start(14);
        wait_done("t5", 100);
        check("t5_restart_beats", beats, 14);

        // 6: done_i re-pulsed mid-stream is ignored
        clear_stats;
        start(14);
        repeat (4) step;
        done_i   = 1'b1;
        size_z_i = 7'd3;
        step;
        done_i   = 1'b0;
        wait_done("t6", 100);
        repeat (5) step;
        check("t6_single_done", done_cnt, exp_done);
        check("t6_beats", beats, 14);

        // 7: oversize request clamps to full memory
        clear_stats;
        start(100);
        wait_done("t7", 200);
        check("t7_beats", beats, 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
